mem_port_arbiter: RTL and testbench

Parametrised N-port arbiter that multiplexes instruction-fetch, load/store and future requesters onto the single byte-serial memory controller. It generalises the two-port fixed "data first, then instruction" scheme to NPORT requesters with selectable round-robin or fixed priority. It also adds store-safe flush: a clear aborts an in-flight read but never an in-flight write. The block sits between the instruction cache / LSB and `memory_controller`.

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-controller handshake bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/controller side.
interface mem_port_arbiter_if #(
    parameter int NPORT = 3,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic [NPORT-1:0]    req_valid;
    logic [NPORT-1:0]    req_wr;
    logic [3*NPORT-1:0]  req_type;
    logic [AW*NPORT-1:0] req_addr;
    logic [DW*NPORT-1:0] req_data;
    logic [NPORT-1:0]    req_ready;
    logic [DW-1:0]       rsp_data;
    logic                mc_valid;
    logic                mc_wr;
    logic [2:0]          mc_type;
    logic [AW-1:0]       mc_addr;
    logic [DW-1:0]       mc_data;
    logic                mc_ready;
    logic [DW-1:0]       mc_res;
    logic                mc_abort;

    modport slave (
        input  req_valid, req_wr, req_type, req_addr, req_data, mc_ready, mc_res,
        output req_ready, rsp_data, mc_valid, mc_wr, mc_type, mc_addr, mc_data, mc_abort
    );

    modport master (
        output req_valid, req_wr, req_type, req_addr, req_data, mc_ready, mc_res,
        input  req_ready, rsp_data, mc_valid, mc_wr, mc_type, mc_addr, mc_data, mc_abort
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-port arbiter onto a single memory controller with store-safe flush.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (port 0 first).
module mem_port_arbiter #(
    parameter int NPORT = 3,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              clear,
    mem_port_arbiter_if.slave bus
);
    localparam int GW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int TW = 3;

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state_r;
    logic [GW-1:0]   g_r;
    logic            cur_wr_r;
    logic            mc_valid_r;
    logic            mc_wr_r;
    logic [TW-1:0]   mc_type_r;
    logic [AW-1:0]   mc_addr_r;
    logic [DW-1:0]   mc_data_r;
`ifdef ARB_ROUND_ROBIN_EN
    logic [GW-1:0]   ptr_r;
`endif

    logic            win_found_s;
    logic [GW-1:0]   win_idx_s;
    int              win_int_s;
    logic            abort_s;
    logic            complete_s;
    logic [NPORT-1:0] req_ready_s;

    // Winner selection over the currently asserted requests.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < NPORT; i++) begin
            if (!win_found_s && bus.req_valid[(int'(ptr_r) + i + 32'sd1) % NPORT]) begin
                win_found_s = 1'b1;
                win_idx_s   = GW'((int'(ptr_r) + i + 32'sd1) % NPORT);
            end else begin
                win_found_s = win_found_s;
            end
        end
`else
        // Scanning downwards leaves the lowest asserted index as the winner.
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                win_found_s = 1'b1;
                win_idx_s   = GW'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
`endif
        win_int_s = int'(win_idx_s);
    end

    // A read is aborted by clear even when mc_ready coincides; a write never is.
    always_comb begin
        abort_s    = clear && (state_r == BUSY) && !cur_wr_r;
        complete_s = (state_r == BUSY) && rdy && bus.mc_ready && !abort_s;
        for (int i = 0; i < NPORT; i++) begin
            req_ready_s[i] = complete_s && (g_r == GW'(i));
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_data  = bus.mc_res;
    assign bus.mc_abort  = abort_s;
    assign bus.mc_valid  = mc_valid_r;
    assign bus.mc_wr     = mc_wr_r;
    assign bus.mc_type   = mc_type_r;
    assign bus.mc_addr   = mc_addr_r;
    assign bus.mc_data   = mc_data_r;

    // Grant / completion state machine with the registered controller request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            g_r        <= '0;
            cur_wr_r   <= 1'b0;
            mc_valid_r <= 1'b0;
            mc_wr_r    <= 1'b0;
            mc_type_r  <= '0;
            mc_addr_r  <= '0;
            mc_data_r  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_r      <= GW'(NPORT - 1);
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (rdy && !clear && win_found_s) begin
                        g_r        <= win_idx_s;
                        cur_wr_r   <= bus.req_wr[win_int_s];
                        mc_valid_r <= 1'b1;
                        mc_wr_r    <= bus.req_wr[win_int_s];
                        mc_type_r  <= bus.req_type[win_int_s*TW +: TW];
                        mc_addr_r  <= bus.req_addr[win_int_s*AW +: AW];
                        mc_data_r  <= bus.req_data[win_int_s*DW +: DW];
                        state_r    <= BUSY;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                BUSY: begin
                    if (abort_s) begin
                        mc_valid_r <= 1'b0;
                        state_r    <= IDLE;
                    end else if (complete_s) begin
                        mc_valid_r <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                        ptr_r      <= g_r;
`endif
                        state_r    <= IDLE;
                    end else begin
                        state_r    <= BUSY;
                    end
                end
                default: begin
                    mc_valid_r <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a policy-level model of grant order and payload forwarding.
module tb_mem_port_arbiter;
    localparam int NPORT = 3;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    logic clear;
    int   checks   = 0;
    int   failures = 0;

    logic [AW-1:0] m_addr [NPORT];
    logic [DW-1:0] m_data [NPORT];
    logic [2:0]    m_type [NPORT];
    logic          m_wr   [NPORT];
    int            last_grant;

    mem_port_arbiter_if #(.NPORT(NPORT), .AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.NPORT(NPORT), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Policy reference: which asserted port should win given the last completed grant.
    function automatic int pick(input logic [NPORT-1:0] v, input int last);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NPORT; k++) begin
            int c;
            c = (last + k) % NPORT;
            if (v[c]) return c;
        end
`else
        for (int k = 0; k < NPORT; k++) begin
            if (v[k]) return k;
        end
`endif
        return -1;
    endfunction

    task automatic set_port(input int p, input logic wr, input logic [2:0] t,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_wr[p] = wr; m_type[p] = t; m_addr[p] = a; m_data[p] = d;
        bus.req_wr[p]             = wr;
        bus.req_type[p*3 +: 3]    = t;
        bus.req_addr[p*AW +: AW]  = a;
        bus.req_data[p*DW +: DW]  = d;
        bus.req_valid[p]          = 1'b1;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mc_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] r;
        r = $urandom;
        rst_n = 1'b0; rdy = 1'b1; clear = 1'b1;
        bus.mc_ready = 1'b1; bus.mc_res = r;
        bus.req_valid = 3'b111; bus.req_wr = 3'b111;
        bus.req_type = 9'h1ff; bus.req_addr = {3{32'hffff_ffff}}; bus.req_data = {3{32'h1234_5678}};
        repeat (2) @(negedge clk);
        checks++; if (bus.mc_valid !== 1'b0) begin failures++; $display("FAIL reset_mc_valid got=%b exp=0", bus.mc_valid); end
        checks++; if (bus.mc_addr !== 32'h0) begin failures++; $display("FAIL reset_mc_addr got=%h exp=0", bus.mc_addr); end
        checks++; if (bus.mc_data !== 32'h0) begin failures++; $display("FAIL reset_mc_data got=%h exp=0", bus.mc_data); end
        checks++; if ({bus.mc_wr, bus.mc_type} !== 4'h0) begin failures++; $display("FAIL reset_mc_wr_type got=%h exp=0", {bus.mc_wr, bus.mc_type}); end
        checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL reset_req_ready got=%b exp=000", bus.req_ready); end
        checks++; if (bus.mc_abort !== 1'b0) begin failures++; $display("FAIL reset_mc_abort got=%b exp=0", bus.mc_abort); end
        checks++; if (bus.rsp_data !== r) begin failures++; $display("FAIL reset_rsp_data got=%h exp=%h", bus.rsp_data, r); end
        clear = 1'b0; bus.mc_ready = 1'b0; bus.req_valid = 3'b000; bus.req_wr = 3'b000;
        rst_n = 1'b1;
        last_grant = NPORT - 1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        bit ok;
        set_port(1, 1'b0, 3'b010, 32'h0000_0100, 32'hcafe_0001);
        wait_grant(ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_grant got=timeout exp=mc_valid"); end
        checks++; if (bus.mc_addr !== 32'h0000_0100) begin failures++; $display("FAIL single_mc_addr got=%h exp=100", bus.mc_addr); end
        checks++; if ({bus.mc_wr, bus.mc_type} !== 4'b0010) begin failures++; $display("FAIL single_wr_type got=%b exp=0010", {bus.mc_wr, bus.mc_type}); end
        repeat (4) begin
            checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL single_early_ready got=%b exp=000", bus.req_ready); end
            @(negedge clk);
        end
        bus.mc_ready = 1'b1; bus.mc_res = 32'hdead_beef;
        #1;
        checks++; if (bus.req_ready !== 3'b010) begin failures++; $display("FAIL single_req_ready got=%b exp=010", bus.req_ready); end
        checks++; if (bus.rsp_data !== 32'hdead_beef) begin failures++; $display("FAIL single_rsp_data got=%h exp=deadbeef", bus.rsp_data); end
        @(negedge clk);
        checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL single_ready_pulse got=%b exp=000", bus.req_ready); end
        checks++; if (bus.mc_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop got=%b exp=0", bus.mc_valid); end
        bus.mc_ready = 1'b0; bus.req_valid[1] = 1'b0;
        last_grant = 1;
    endtask

    task automatic test_arbitration();
        bit ok;
        int exp_q[$];
        logic [NPORT-1:0] er;
        logic [DW-1:0] r;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_grant = NPORT - 1;
`ifdef ARB_ROUND_ROBIN_EN
        exp_q = '{0, 1, 2, 0};
`else
        exp_q = '{0, 0, 0};
`endif
        for (int p = 0; p < NPORT; p++) set_port(p, 1'b0, 3'b010, 32'h1000 + 32'(p * 16), $urandom);
        foreach (exp_q[i]) begin
            wait_grant(ok);
            checks++; if (!ok) begin failures++; $display("FAIL arb_grant_%0d got=timeout exp=mc_valid", i); end
            checks++; if (bus.mc_addr !== 32'h1000 + 32'(exp_q[i] * 16)) begin failures++; $display("FAIL arb_order_%0d got_addr=%h exp_port=%0d", i, bus.mc_addr, exp_q[i]); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r = $urandom;
            bus.mc_ready = 1'b1; bus.mc_res = r;
            er = '0; er[exp_q[i]] = 1'b1;
            #1;
            checks++; if (bus.req_ready !== er) begin failures++; $display("FAIL arb_ready_%0d got=%b exp=%b", i, bus.req_ready, er); end
            @(negedge clk);
            checks++; if (bus.mc_valid !== 1'b0) begin failures++; $display("FAIL arb_gap_%0d got=%b exp=0", i, bus.mc_valid); end
            bus.mc_ready = 1'b0;
            last_grant = exp_q[i];
        end
        bus.req_valid = 3'b000;
    endtask

    task automatic test_clear_read();
        bit ok;
        set_port(2, 1'b0, 3'b100, 32'h0000_2000, 32'h0);
        clear = 1'b1;
        @(negedge clk);
        checks++; if (bus.mc_valid !== 1'b0) begin failures++; $display("FAIL clear_idle_no_grant got=%b exp=0", bus.mc_valid); end
        clear = 1'b0;
        wait_grant(ok);
        checks++; if (!ok || bus.mc_addr !== 32'h0000_2000) begin failures++; $display("FAIL clear_read_grant got=%h exp=2000", bus.mc_addr); end
        @(negedge clk);
        clear = 1'b1; bus.mc_ready = 1'b1;
        #1;
        checks++; if (bus.mc_abort !== 1'b1) begin failures++; $display("FAIL clear_read_abort got=%b exp=1", bus.mc_abort); end
        checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL clear_read_no_ready got=%b exp=000", bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.mc_valid !== 1'b0) begin failures++; $display("FAIL clear_read_valid_drop got=%b exp=0", bus.mc_valid); end
        checks++; if (bus.mc_abort !== 1'b0) begin failures++; $display("FAIL clear_read_abort_idle got=%b exp=0", bus.mc_abort); end
        clear = 1'b0; bus.mc_ready = 1'b0; bus.req_valid[2] = 1'b0;
        set_port(2, 1'b0, 3'b000, 32'h0000_2040, 32'h0);
        wait_grant(ok);
        checks++; if (!ok || bus.mc_addr !== 32'h0000_2040) begin failures++; $display("FAIL clear_read_regrant got=%h exp=2040", bus.mc_addr); end
        bus.mc_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 3'b100) begin failures++; $display("FAIL clear_read_after_ready got=%b exp=100", bus.req_ready); end
        @(negedge clk);
        bus.mc_ready = 1'b0; bus.req_valid[2] = 1'b0;
        last_grant = 2;
    endtask

    task automatic test_clear_write();
        bit ok;
        set_port(0, 1'b1, 3'b010, 32'h0003_0000, 32'h0000_0055);
        wait_grant(ok);
        checks++; if (!ok || bus.mc_wr !== 1'b1 || bus.mc_addr !== 32'h0003_0000) begin failures++; $display("FAIL clear_write_grant got_wr=%b got_addr=%h exp=1/30000", bus.mc_wr, bus.mc_addr); end
        @(negedge clk);
        clear = 1'b1;
        #1;
        checks++; if (bus.mc_abort !== 1'b0) begin failures++; $display("FAIL clear_write_abort got=%b exp=0", bus.mc_abort); end
        @(negedge clk);
        checks++; if (bus.mc_valid !== 1'b1 || bus.mc_data !== 32'h0000_0055) begin failures++; $display("FAIL clear_write_held got_v=%b got_d=%h exp=1/55", bus.mc_valid, bus.mc_data); end
        bus.mc_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 3'b001) begin failures++; $display("FAIL clear_write_ready got=%b exp=001", bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.mc_valid !== 1'b0) begin failures++; $display("FAIL clear_write_done got=%b exp=0", bus.mc_valid); end
        clear = 1'b0; bus.mc_ready = 1'b0; bus.req_valid[0] = 1'b0;
        last_grant = 0;
    endtask

    task automatic test_rdy_stall();
        bit ok;
        set_port(1, 1'b0, 3'b001, 32'h0000_4000, 32'h0);
        rdy = 1'b0;
        @(negedge clk);
        checks++; if (bus.mc_valid !== 1'b0) begin failures++; $display("FAIL rdy_idle_no_grant got=%b exp=0", bus.mc_valid); end
        rdy = 1'b1;
        wait_grant(ok);
        checks++; if (!ok || bus.mc_addr !== 32'h0000_4000) begin failures++; $display("FAIL rdy_grant got=%h exp=4000", bus.mc_addr); end
        rdy = 1'b0; bus.mc_ready = 1'b1; bus.mc_res = 32'h0bad_f00d;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL rdy_stall_ready_%0d got=%b exp=000", i, bus.req_ready); end
            @(negedge clk);
            checks++; if (bus.mc_valid !== 1'b1 || bus.mc_addr !== 32'h0000_4000) begin failures++; $display("FAIL rdy_stall_hold_%0d got_v=%b got_a=%h exp=1/4000", i, bus.mc_valid, bus.mc_addr); end
        end
        rdy = 1'b1; bus.mc_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.mc_valid !== 1'b1) begin failures++; $display("FAIL rdy_resume_busy got=%b exp=1", bus.mc_valid); end
        bus.mc_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 3'b010 || bus.rsp_data !== 32'h0bad_f00d) begin failures++; $display("FAIL rdy_complete got_r=%b got_d=%h exp=010/0badf00d", bus.req_ready, bus.rsp_data); end
        @(negedge clk);
        checks++; if (bus.mc_valid !== 1'b0) begin failures++; $display("FAIL rdy_done got=%b exp=0", bus.mc_valid); end
        bus.mc_ready = 1'b0; bus.req_valid[1] = 1'b0;
        last_grant = 1;
    endtask

    task automatic test_async_reset();
        bit ok;
        set_port(0, 1'b0, 3'b100, 32'h0000_5000, 32'h0);
        wait_grant(ok);
        checks++; if (!ok) begin failures++; $display("FAIL arst_grant got=timeout exp=mc_valid"); end
        #3;
        rst_n = 1'b0; bus.mc_ready = 1'b1;
        #1;
        checks++; if (bus.mc_valid !== 1'b0 || bus.mc_addr !== 32'h0) begin failures++; $display("FAIL arst_outputs got_v=%b got_a=%h exp=0/0", bus.mc_valid, bus.mc_addr); end
        checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL arst_ready got=%b exp=000", bus.req_ready); end
        clear = 1'b1;
        #1;
        checks++; if (bus.mc_abort !== 1'b0) begin failures++; $display("FAIL arst_abort got=%b exp=0", bus.mc_abort); end
        @(negedge clk);
        rst_n = 1'b1; clear = 1'b0; bus.req_valid[0] = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL arst_idle_ignores_ready got=%b exp=000", bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.mc_valid !== 1'b0) begin failures++; $display("FAIL arst_stays_idle got=%b exp=0", bus.mc_valid); end
        bus.mc_ready = 1'b0;
        last_grant = NPORT - 1;
    endtask

    task automatic test_random();
        bit ok;
        bit do_abort;
        int ex;
        logic [NPORT-1:0] pend;
        logic [NPORT-1:0] er;
        logic [DW-1:0] r;
        pend = '0;
        for (int t = 0; t < 60; t++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    set_port(p, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
                    pend[p] = 1'b1;
                end
            end
            if (pend == '0) begin
                ex = $urandom_range(0, NPORT - 1);
                set_port(ex, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
                pend[ex] = 1'b1;
            end
            ex = pick(pend, last_grant);
            wait_grant(ok);
            checks++; if (!ok) begin failures++; $display("FAIL rand_grant_%0d got=timeout exp=mc_valid", t); break; end
            checks++;
            if (bus.mc_addr !== m_addr[ex] || bus.mc_data !== m_data[ex] || bus.mc_wr !== m_wr[ex] || bus.mc_type !== m_type[ex]) begin
                failures++;
                $display("FAIL rand_payload_%0d got=%h/%h/%b/%h exp_port=%0d exp=%h/%h/%b/%h", t, bus.mc_addr, bus.mc_data, bus.mc_wr, bus.mc_type, ex, m_addr[ex], m_data[ex], m_wr[ex], m_type[ex]);
            end
            repeat ($urandom_range(0, 3)) begin
                rdy = ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
            rdy = 1'b1;
            do_abort = !m_wr[ex] && ($urandom_range(0, 5) == 0);
            r = $urandom;
            bus.mc_res = r;
            if (do_abort) begin
                clear = 1'b1; bus.mc_ready = 1'($urandom_range(0, 1)); rdy = 1'($urandom_range(0, 1));
                #1;
                checks++; if (bus.mc_abort !== 1'b1 || bus.req_ready !== 3'b000) begin failures++; $display("FAIL rand_abort_%0d got_ab=%b got_r=%b exp=1/000", t, bus.mc_abort, bus.req_ready); end
            end else begin
                clear = m_wr[ex] && ($urandom_range(0, 2) == 0);
                bus.mc_ready = 1'b1;
                er = '0; er[ex] = 1'b1;
                #1;
                checks++; if (bus.req_ready !== er || bus.rsp_data !== r || bus.mc_abort !== 1'b0) begin failures++; $display("FAIL rand_complete_%0d got_r=%b got_d=%h got_ab=%b exp=%b/%h/0", t, bus.req_ready, bus.rsp_data, bus.mc_abort, er, r); end
                last_grant = ex;
            end
            @(negedge clk);
            checks++; if (bus.mc_valid !== 1'b0) begin failures++; $display("FAIL rand_gap_%0d got=%b exp=0", t, bus.mc_valid); end
            clear = 1'b0; bus.mc_ready = 1'b0; rdy = 1'b1;
            bus.req_valid[ex] = 1'b0; pend[ex] = 1'b0;
        end
        bus.req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_arbitration();
        test_clear_read();
        test_clear_write();
        test_rdy_stall();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
